// File: rtl/multi_timer_pkg.sv
// Shared types and constants for the multi-channel timer.
//   chan_state_t : per-channel FSM state (IDLE, RUN, DONE)
//   ONESHOT / PERIODIC : values of a channel's mode bit
package multi_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chan_state_t;

  localparam logic ONESHOT  = 1'b0;
  localparam logic PERIODIC = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: reload register, down-counter and control FSM.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   step_i         : shared prescaler step (one cycle wide)
//   load_i, d_i    : load strobe and reload value
//   en_i, mode_i   : count enable, mode (ONESHOT/PERIODIC)
//   tick_o         : one-cycle expiry pulse (registered)
//   busy_o         : high while in RUN
//   q_o            : current count (registered)
//
// state | meaning
// IDLE  | after reset, waiting for a load
// RUN   | counting down on enabled steps
// DONE  | one-shot expired, count parked at 0, waiting for a load
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  input  logic             mode_i,
  output logic             tick_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] q_o
);

  chan_state_t      state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tick_q, tick_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tick_d   = 1'b0;
    // A load wins over a coincident step, so an expiry in the same cycle is dropped.
    if (load_i) begin
      reload_d = d_i;
      cnt_d    = d_i;
      state_d  = RUN;
    end else if (state_q == RUN && en_i && step_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else begin
        tick_d = 1'b1;
        if (mode_i == PERIODIC) begin
          cnt_d = reload_q;
        end else begin
          state_d = DONE;
        end
      end
    end
  end

  assign tick_o = tick_q;
  assign busy_o = (state_q == RUN);
  assign q_o    = cnt_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel programmable timer with a shared prescaler.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   presc_i      : prescaler terminal value (step every presc_i+1 cycles)
//   load_i       : per-channel load strobe
//   d_i          : per-channel reload value, channel c at [c*WIDTH +: WIDTH]
//   en_i         : per-channel count enable
//   mode_i       : per-channel mode, 0 one-shot / 1 periodic
//   tick_o       : per-channel one-cycle expiry pulse
//   busy_o       : per-channel RUN flag
//   q_o          : per-channel current count, packed like d_i
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int PRESC_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [PRESC_W-1:0]        presc_i,
  input  logic [CHANNELS-1:0]       load_i,
  input  logic [CHANNELS*WIDTH-1:0] d_i,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [CHANNELS-1:0]       mode_i,
  output logic [CHANNELS-1:0]       tick_o,
  output logic [CHANNELS-1:0]       busy_o,
  output logic [CHANNELS*WIDTH-1:0] q_o
);

  logic [PRESC_W-1:0] presc_q;
  logic               step;

  assign step = (presc_q == presc_i);

  // If presc_i drops below the running count, the increment simply wraps
  // through the all-ones value back to 0 and the compare catches up then.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
    end else if (step) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    timer_channel #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .step_i (step),
      .load_i (load_i[c]),
      .d_i    (d_i[c*WIDTH +: WIDTH]),
      .en_i   (en_i[c]),
      .mode_i (mode_i[c]),
      .tick_o (tick_o[c]),
      .busy_o (busy_o[c]),
      .q_o    (q_o[c*WIDTH +: WIDTH])
    );
  end

endmodule
